// File: rtl/multi_pulse_sync_rx_pkg.sv
// Shared types and helpers for the multi-channel toggle event receiver.
// Pure declarations: no logic, no latency, no flow control.
package pulse_sync_pkg;

  typedef enum logic {ST_IDLE, ST_OFFER} rx_state_t;

  localparam int SYNC_STAGES_MIN = 2;

  // Round-robin pointer advance with wrap back to channel 0.
  function automatic int rr_next(input int cur, input int num_ch);
    return (cur >= num_ch - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/multi_pulse_sync_rx_sync_cell.sv
// One-channel toggle synchronizer with history flop and edge detect.
// edge_o valid SYNC_STAGES cycles after sampling; pulse_o one cycle later; no backpressure.
module toggle_sync_cell
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic tgl_i,
  output logic edge_o,
  output logic pulse_o
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("toggle_sync_cell: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   pulse_q;

  assign edge_o  = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign pulse_o = pulse_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], tgl_i};
      hist_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= edge_o;
    end
  end

endmodule

// File: rtl/multi_pulse_sync_rx.sv
// Multi-channel toggle receiver: per-channel pending counters, round-robin valid/ready event port.
// Event offered SYNC_STAGES+2 cycles after sampling; offer held until ready; overflow flag under PULSE_SYNC_OVF_EN.
module multi_pulse_sync_rx
  import pulse_sync_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NUM_CH-1:0] tgl_i,
  output logic [NUM_CH-1:0] pulse_o,
  output logic [NUM_CH-1:0] pend_o,
  output logic              ev_valid_o,
  output logic [CH_W-1:0]   ev_ch_o,
  input  logic              ev_ready_i,
  output logic [NUM_CH-1:0] ovf_o,
  input  logic [NUM_CH-1:0] ovf_clr_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] edge_w;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] dec_w;
  logic [NUM_CH-1:0] sat_w;

  rx_state_t       state_q, state_d;
  logic [CH_W-1:0] ev_ch_q, rr_q, pick;
  logic            pick_vld, load, accept;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    toggle_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .tgl_i  (tgl_i[c]),
      .edge_o (edge_w[c]),
      .pulse_o(pulse_o[c])
    );
    assign pend_o[c] = (cnt_q[c] != '0);
  end

  // Scan downwards so the smallest offset from rr_q wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      idx = int'(rr_q) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (pend_o[idx]) begin
        pick     = CH_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    accept     = 1'b0;
    ev_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          load    = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        ev_valid_o = 1'b1;
        if (ev_ready_i) begin
          accept  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ev_ch_o = ev_ch_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      ev_ch_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load)   ev_ch_q <= pick;
      if (accept) rr_q    <= CH_W'(rr_next(int'(ev_ch_q), NUM_CH));
    end
  end

  // An edge arriving at a full counter with no accept is dropped (saturation).
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      dec_w[c] = accept && (ev_ch_q == CH_W'(c));
      sat_w[c] = edge_w[c] && !dec_w[c] && (cnt_q[c] == CNT_MAX);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (edge_w[c] && !dec_w[c] && !sat_w[c]) cnt_q[c] <= cnt_q[c] + 1'b1;
        else if (!edge_w[c] && dec_w[c])         cnt_q[c] <= cnt_q[c] - 1'b1;
      end
    end
  end

`ifdef PULSE_SYNC_OVF_EN
  logic [NUM_CH-1:0] ovf_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ovf_q <= '0;
    else         ovf_q <= sat_w | (ovf_q & ~ovf_clr_i);
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ^ovf_clr_i;
  assign ovf_o          = '0;
`endif

endmodule

// File: doc/multi_pulse_sync_rx.md
Name: multi_pulse_sync_rx

Overview:
- Destination-side, multi-channel event receiver for crossings from a faster source domain (e.g. DMAC 100 MHz -> 50 MHz).
- Each channel takes a source-generated toggle (level flips once per event) and synchronizes it through a parametrised flop chain.
- Detected toggles are counted per channel, so back-to-back events are never lost.
- A registered round-robin arbiter presents pending events one at a time on a valid/ready interface to the destination logic.

Parameters:
NUM_CH, 4, number of independent event channels (1..16)
SYNC_STAGES, 2, synchronizer flops per channel (>= 2)
CNT_W, 4, width of per-channel pending-event counter (max pending = 2^CNT_W-1)

Ports:
clk_i  input  1  destination clock
rstn_i  input  1  asynchronous active-low reset
tgl_i  input  NUM_CH  asynchronous toggle inputs; one flip = one event
pulse_o  output  NUM_CH  one-cycle registered pulse per detected toggle
pend_o  output  NUM_CH  channel has pending count != 0
ev_valid_o  output  1  event offered
ev_ch_o  output  $clog2(NUM_CH) (min 1)  channel index of offered event
ev_ready_i  input  1  consumer accepts event
ovf_o  output  NUM_CH  sticky overflow flag per channel
ovf_clr_i  input  NUM_CH  per-channel overflow clear (single cycle)

Behaviour:
- Reset (async assert, sync release by system): sync chains, history flops, counters, rr pointer = 0, FSM = ST_IDLE; all outputs 0. Source toggles must also be 0 at reset. Reset mid-operation discards all pending events.
- Per channel: s[1..SYNC_STAGES] chain, hist <= s[SYNC_STAGES]; edge = s[SYNC_STAGES] ^ hist.
- Latency: tgl_i flip sampled at edge 1 -> pulse_o high and cnt incremented after edge SYNC_STAGES+1 (edge 3 for default) -> ev_valid_o high after edge SYNC_STAGES+2.
- Counter: +1 on edge, -1 on accept of that channel, both in the same cycle -> unchanged. Increment at cnt = max saturates (event lost).
- FSM ST_IDLE: if any pend, latch lowest-index pending channel at/after rr pointer (wrapping) into ev_ch_q, go ST_OFFER. Else stay.
- FSM ST_OFFER: ev_valid_o = 1, ev_ch_o = ev_ch_q, both stable until accepted. On ev_valid_o & ev_ready_i: decrement cnt[ev_ch_q], rr <= ev_ch_q+1 (wrap at NUM_CH-1 -> 0), go ST_IDLE.
- Throughput: one accepted event per 2 cycles.
- ev_ready_i may be high before valid. No combinational path from ev_ready_i to ev_valid_o.
- Channel in ST_OFFER with cnt 1 plus a new edge in the same cycle as accept: cnt stays 1, channel re-eligible next IDLE.
- Source constraint (documented, asserted in bench): toggles on one channel spaced >= SYNC_STAGES+1 destination cycles. Closer toggles may merge.

Optional Feature:
- Macro: PULSE_SYNC_OVF_EN.
- Defined: increment at saturation sets ovf_o[ch]. ovf_clr_i[ch] clears it next cycle. Set wins over a simultaneous clear.
- Undefined: ovf_o driven 0, ovf_clr_i ignored; saturation still applies silently.

Decomposition:
- Package pulse_sync_pkg: typedef enum logic {ST_IDLE, ST_OFFER} rx_state_t; localparam SYNC_STAGES_MIN = 2; function for rr next-pointer wrap.
- Sub-module toggle_sync_cell (param SYNC_STAGES): chain + hist + registered edge pulse. Instantiated NUM_CH times via generate. Counters, arbiter and FSM stay in top.
- Elaboration check: SYNC_STAGES < SYNC_STAGES_MIN is an error.

Test Plan:
- Single event: flip tgl_i[2] 0->1, ev_ready_i=1 -> pulse_o[2] one cycle after edge 3; ev_valid_o after edge 4 with ev_ch_o=2; accepted, pend_o[2]=0.
- Burst: 3 toggles on ch0 spaced 3 cycles, ev_ready_i=0 -> cnt reaches 3, ev_ch_o=0 held stable. Raise ready -> exactly 3 events of ch 0.
- Round-robin: all 4 channels toggle once simultaneously, ready=1 -> accept order 0,1,2,3. Repeat after rr=1 with ch0 and ch3 pending -> order 3,0.
- Simultaneous inc/dec: ch1 cnt=1 offered; new ch1 edge on accept cycle -> cnt stays 1, second ch1 event offered.
- Overflow (PULSE_SYNC_OVF_EN, CNT_W=2): 4 toggles, ready=0 -> cnt=3, ovf_o=1. ovf_clr_i pulse -> ovf_o=0. Without macro -> ovf_o stays 0.
- Reset mid-operation: rstn_i low while ST_OFFER with cnt=2 -> all outputs 0 immediately, no events after release.
